// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// RST_SEQ_STAGGER_ASSERT_EN adds the staggered-assert state.
package rst_seq_pkg;

    localparam int DEF_NUM_DOM     = 3;
    localparam int DEF_NUM_REQ     = 3;
    localparam int DEF_HOLD_CYC    = 16;
    localparam int DEF_ACK_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_ACK,
        ST_IDLE
`ifdef RST_SEQ_STAGGER_ASSERT_EN
        , ST_STAGGER
`endif
    } state_t;

    function automatic int cnt_w(input int hold, input int tmo);
        int m;
        m = (hold > tmo) ? hold : tmo;
        return $clog2(m + 1);
    endfunction

    // Drops the highest released domain; used to walk resets down.
    function automatic logic [7:0] clr_msb(input logic [7:0] v);
        logic [7:0] r;
        logic       hit;
        r   = v;
        hit = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!hit && v[i]) begin
                r[i] = 1'b0;
                hit  = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_cnt.sv
// Loadable down-counter shared by the hold and ack-timeout phases.
// Saturates at zero; zero flag is decoded from the register.
module rst_seq_cnt #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts all domain resets, holds, then releases in order.
// Optional RST_SEQ_STAGGER_ASSERT_EN staggers assertion high-to-low.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = DEF_NUM_DOM,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_DOM-1:0] dom_ack,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [NUM_REQ-1:0] cause
);

    localparam int CNT_W = cnt_w(HOLD_CYC, ACK_TIMEOUT);
    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0]   HOLD_V = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0]   ACK_V  = CNT_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0]   LAST   = IDX_W'(NUM_DOM - 1);
    localparam logic [NUM_DOM-1:0] ONE    = NUM_DOM'(1);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [NUM_DOM-1:0] dom_n;
    logic               terr_n;
    logic [NUM_REQ-1:0] cause_n;

    logic               cnt_load;
    logic               cnt_en;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;
    logic               ack_ok;

`ifdef RST_SEQ_STAGGER_ASSERT_EN
    logic [7:0]         stag_w;
    logic [NUM_DOM-1:0] dom_dn;
`endif

    rst_seq_cnt #(
        .W       (CNT_W),
        .RST_VAL (HOLD_V)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ASSERT;
            idx         <= '0;
            dom_rst_n   <= '0;
            timeout_err <= 1'b0;
            cause       <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            dom_rst_n   <= dom_n;
            timeout_err <= terr_n;
            cause       <= cause_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        dom_n    = dom_rst_n;
        terr_n   = timeout_err;
        cause_n  = cause;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = HOLD_V;
        ack_ok   = dom_ack[idx];
`ifdef RST_SEQ_STAGGER_ASSERT_EN
        stag_w   = clr_msb(8'(dom_rst_n));
        dom_dn   = stag_w[NUM_DOM-1:0];
`endif
        if (|req) begin
            idx_n = '0;
            if (state == ST_IDLE) begin
                cause_n = req;
                terr_n  = 1'b0;
            end else begin
                cause_n = cause | req;
            end
`ifdef RST_SEQ_STAGGER_ASSERT_EN
            dom_n = dom_dn;
            if (dom_dn == '0) begin
                state_n  = ST_ASSERT;
                cnt_load = 1'b1;
            end else begin
                state_n  = ST_STAGGER;
            end
`else
            state_n  = ST_ASSERT;
            dom_n    = '0;
            cnt_load = 1'b1;
`endif
        end else begin
            unique case (state)
                ST_ASSERT: begin
                    if (cnt_zero) begin
                        state_n  = ST_WAIT_ACK;
                        idx_n    = '0;
                        dom_n    = ONE;
                        cnt_load = 1'b1;
                        cnt_val  = ACK_V;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    // A timeout advances exactly like an ack, but is flagged.
                    if (ack_ok || cnt_zero) begin
                        if (!ack_ok) begin
                            terr_n = 1'b1;
                        end
                        if (idx == LAST) begin
                            state_n = ST_IDLE;
                        end else begin
                            idx_n    = idx + IDX_W'(1);
                            dom_n    = (dom_rst_n << 1) | ONE;
                            cnt_load = 1'b1;
                            cnt_val  = ACK_V;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
`ifdef RST_SEQ_STAGGER_ASSERT_EN
                ST_STAGGER: begin
                    dom_n = dom_dn;
                    if (dom_dn == '0) begin
                        state_n  = ST_ASSERT;
                        cnt_load = 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_IDLE);

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl against a released-count model.
// Honours RST_SEQ_STAGGER_ASSERT_EN in the reference model.
module tb_rst_seq_ctrl;

    localparam int ND = 3;
    localparam int NR = 3;
    localparam int HC = 4;
    localparam int AT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [ND-1:0] dom_ack;
    logic [ND-1:0] dom_rst_n;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [NR-1:0] cause;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NUM_DOM     (ND),
        .NUM_REQ     (NR),
        .HOLD_CYC    (HC),
        .ACK_TIMEOUT (AT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .dom_ack     (dom_ack),
        .dom_rst_n   (dom_rst_n),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .cause       (cause)
    );

    int errors = 0;
    int checks = 0;

    // Model: phase, number of released domains, cycles left in phase.
    typedef enum {M_HOLD, M_WAIT, M_IDLE, M_STAG} mph_t;
    mph_t          ph = M_HOLD;
    int            rel = 0;
    int            left = HC;
    logic [NR-1:0] m_cause = '0;
    logic          m_terr = 1'b0;

    int            age [ND];
    logic [ND-1:0] stuck = '0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [NR-1:0] q,
                              input logic [ND-1:0] a);
        if (r) begin
            ph = M_HOLD; rel = 0; left = HC;
            m_cause = '0; m_terr = 1'b0;
        end else if (q != '0) begin
            if (ph == M_IDLE) begin
                m_cause = q; m_terr = 1'b0;
            end else begin
                m_cause = m_cause | q;
            end
`ifdef RST_SEQ_STAGGER_ASSERT_EN
            if (rel > 1) begin
                ph = M_STAG; rel = rel - 1;
            end else begin
                ph = M_HOLD; rel = 0; left = HC;
            end
`else
            ph = M_HOLD; rel = 0; left = HC;
`endif
        end else begin
            case (ph)
                M_HOLD: begin
                    if (left == 0) begin
                        rel = 1; ph = M_WAIT; left = AT;
                    end else left--;
                end
                M_WAIT: begin
                    if (a[rel-1] || left == 0) begin
                        if (!a[rel-1]) m_terr = 1'b1;
                        if (rel == ND) ph = M_IDLE;
                        else begin
                            rel++; left = AT;
                        end
                    end else left--;
                end
                M_STAG: begin
                    rel--;
                    if (rel == 0) begin
                        ph = M_HOLD; left = HC;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: model follows the inputs present at the edge.
    task automatic tick();
        logic          r;
        logic [NR-1:0] q;
        logic [ND-1:0] a;
        logic [ND-1:0] edom;
        r = rst; q = req; a = dom_ack;
        @(posedge clk);
        model_step(r, q, a);
        #1;
        edom = ND'((1 << rel) - 1);
        chk("dom_rst_n", 8'(dom_rst_n), 8'(edom));
        chk("busy", 8'(busy), 8'(ph != M_IDLE));
        chk("done", 8'(done), 8'(ph == M_IDLE));
        chk("timeout_err", 8'(timeout_err), 8'(m_terr));
        chk("cause", 8'(cause), 8'(m_cause));
        // Ack rises two cycles after the domain's reset is released.
        for (int i = 0; i < ND; i++) begin
            age[i] = (dom_rst_n[i] === 1'b1) ? age[i] + 1 : 0;
            dom_ack[i] = (age[i] >= 3) && !stuck[i];
        end
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 8'(done), 8'd1);
    endtask

    task automatic run_until_dom(input logic [ND-1:0] v, input int budget);
        int n;
        n = 0;
        while (dom_rst_n !== v && n < budget) begin
            tick();
            n++;
        end
        chk("reach_dom", 8'(dom_rst_n), 8'(v));
    endtask

    initial begin
        rst = 1'b1; req = '0; dom_ack = '0;
        for (int i = 0; i < ND; i++) age[i] = 0;

        tick(); tick();
        chk("rst_dom", 8'(dom_rst_n), 8'h0);
        chk("rst_busy", 8'(busy), 8'h1);
        rst = 1'b0;

        // Power-up sequence with no request.
        repeat (4) tick();
        chk("pu_hold", 8'(dom_rst_n), 8'h0);
        tick();
        chk("pu_rel0", 8'(dom_rst_n), 8'h1);
        repeat (3) tick();
        chk("pu_rel1", 8'(dom_rst_n), 8'h3);
        repeat (3) tick();
        chk("pu_rel2", 8'(dom_rst_n), 8'h7);
        repeat (3) tick();
        chk("pu_done", 8'(done), 8'h1);
        chk("pu_cause", 8'(cause), 8'h0);
        chk("pu_terr", 8'(timeout_err), 8'h0);

        // Request from idle.
        req = 3'b010; tick(); req = '0;
        chk("req_cause", 8'(cause), 8'h2);
        chk("req_busy", 8'(busy), 8'h1);
`ifndef RST_SEQ_STAGGER_ASSERT_EN
        chk("req_dom", 8'(dom_rst_n), 8'h0);
`else
        chk("stag_first", 8'(dom_rst_n), 8'h3);
        tick();
        chk("stag_second", 8'(dom_rst_n), 8'h1);
        tick();
        chk("stag_third", 8'(dom_rst_n), 8'h0);
        repeat (4) tick();
        chk("stag_hold", 8'(dom_rst_n), 8'h0);
        tick();
        chk("stag_rel0", 8'(dom_rst_n), 8'h1);
`endif
        run_until_done("req_done", 60);

        // Restart during WAIT_ACK(1).
        req = 3'b100; tick(); req = '0;
        run_until_dom(3'b011, 60);
        req = 3'b001; tick(); req = '0;
        chk("rs_cause", 8'(cause), 8'h5);
`ifndef RST_SEQ_STAGGER_ASSERT_EN
        chk("rs_dom", 8'(dom_rst_n), 8'h0);
        repeat (4) tick();
        chk("rs_hold", 8'(dom_rst_n), 8'h0);
        tick();
        chk("rs_rel0", 8'(dom_rst_n), 8'h1);
`endif
        run_until_done("rs_done", 60);

        // Stuck ack on domain 1 forces a timeout.
        stuck = 3'b010;
        req = 3'b100; tick(); req = '0;
        chk("to_clear", 8'(timeout_err), 8'h0);
        run_until_done("to_done", 80);
        chk("to_err", 8'(timeout_err), 8'h1);
        chk("to_dom", 8'(dom_rst_n), 8'h7);
        repeat (3) tick();
        chk("to_sticky", 8'(timeout_err), 8'h1);
        stuck = '0;

        // Held request, then sync reset mid-sequence.
        req = 3'b001;
        repeat (10) tick();
        chk("held_dom", 8'(dom_rst_n), 8'h0);
        req = '0;
        repeat (4) tick();
        chk("held_hold", 8'(dom_rst_n), 8'h0);
        tick();
        chk("held_rel0", 8'(dom_rst_n), 8'h1);
        run_until_dom(3'b011, 20);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_dom", 8'(dom_rst_n), 8'h0);
        chk("mid_rst_cause", 8'(cause), 8'h0);
        chk("mid_rst_terr", 8'(timeout_err), 8'h0);
        run_until_done("mid_rst_done", 60);

        // Randomized requests, resets and stuck acks.
        for (int k = 0; k < 600; k++) begin
            req = ($urandom_range(0, 19) == 0) ?
                  NR'($urandom_range(1, 7)) : '0;
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) stuck = ND'($urandom);
            tick();
        end
        req = '0; rst = 1'b0; stuck = '0;
        run_until_done("rand_done", 120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
